// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register for the 32-bit RISC-V pipeline.
// Issues PC requests to a variable-latency in-order memory and queues the returned words for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [6:0]  opD,
  output logic [2:0]  funct3D,
  output logic        funct7b5D
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  // Handshake: a request transfers on a rising edge where ImemReqValid && ImemReqReady;
  // a response transfers on a rising edge where ImemRespValid is high and a request is in flight.

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   pcf;
  logic [31:0]   tag_mem   [DEPTH];
  logic [PW-1:0] tag_wr, tag_rd;
  logic [CW-1:0] inflight, inflight_nx;

  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] buf_wr, buf_rd;
  logic [CW-1:0] buffered, buffered_nx;

  logic [CW-1:0] drop, drop_nx;

  logic [31:0]   instr_q, pc_q, pc4_q;
  logic          valid_q;

  logic [CW:0]   credit_sum;
  logic          req_valid, accept;
  logic          resp_pop, resp_drop, resp_push;
  logic          id_advance, id_pop;
  logic [31:0]   head_instr, head_pc;

  // Credits use start-of-cycle counts so a same-cycle pop never lets a request overrun the buffer.
  always_comb begin
    credit_sum = {1'b0, inflight} + {1'b0, buffered};
    req_valid  = reset && (credit_sum < DEPTH_C) && !PCSrcE;
    accept     = req_valid && ImemReqReady;
    resp_pop   = ImemRespValid && (inflight != '0);
    resp_drop  = resp_pop && (drop != '0);
    resp_push  = resp_pop && !resp_drop && !PCSrcE;
    id_advance = !PCSrcE && !FlushD && !StallD;
    id_pop     = id_advance && (buffered != '0);
    head_instr = buf_instr[buf_rd];
    head_pc    = buf_pc[buf_rd];
  end

  always_comb begin
    inflight_nx = inflight;
    if (accept && !resp_pop) begin
      inflight_nx = inflight + CW'(1);
    end else if (!accept && resp_pop) begin
      inflight_nx = inflight - CW'(1);
    end
  end

  always_comb begin
    buffered_nx = buffered;
    if (PCSrcE) begin
      buffered_nx = '0;
    end else if (resp_push && !id_pop) begin
      buffered_nx = buffered + CW'(1);
    end else if (!resp_push && id_pop) begin
      buffered_nx = buffered - CW'(1);
    end
  end

  // On a redirect every response still owed by memory belongs to the old path.
  always_comb begin
    drop_nx = drop;
    if (PCSrcE) begin
      drop_nx = inflight_nx;
    end else if (resp_drop) begin
      drop_nx = drop - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf      <= RESET_PC;
      tag_wr   <= '0;
      tag_rd   <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nx;
      drop     <= drop_nx;
      if (PCSrcE) begin
        pcf <= PCTargetE;
      end else if (accept) begin
        pcf <= pcf + 32'd4;
      end
      if (accept) begin
        tag_wr <= ptr_inc(tag_wr);
      end
      if (resp_pop) begin
        tag_rd <= ptr_inc(tag_rd);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_wr   <= '0;
      buf_rd   <= '0;
      buffered <= '0;
    end else begin
      buffered <= buffered_nx;
      if (PCSrcE) begin
        buf_wr <= '0;
        buf_rd <= '0;
      end else begin
        if (resp_push) begin
          buf_wr <= ptr_inc(buf_wr);
        end
        if (id_pop) begin
          buf_rd <= ptr_inc(buf_rd);
        end
      end
    end
  end

  // Storage arrays carry no reset; their contents are qualified by the pointers and counters.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[tag_wr] <= pcf;
    end
    if (resp_push) begin
      buf_instr[buf_wr] <= ImemRespData;
      buf_pc[buf_wr]    <= tag_mem[tag_rd];
    end
  end

  // Bubbles keep PCD/PCPlus4D so downstream sees a stable PC on a non-valid slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!StallD) begin
      if (buffered != '0) begin
        instr_q <= head_instr;
        pc_q    <= head_pc;
        pc4_q   <= head_pc + 32'd4;
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end
    end
  end

  assign ImemReqValid = req_valid;
  assign ImemAddr     = pcf;
  assign InstrD       = instr_q;
  assign PCD          = pc_q;
  assign PCPlus4D     = pc4_q;
  assign ValidD       = valid_q;
  assign opD          = instr_q[6:0];
  assign funct3D      = instr_q[14:12];
  assign funct7b5D    = instr_q[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-level reference model of fetch/buffer/ID plus an in-order memory model.
// Directed scenarios with literal expectations, then a randomized run compared every cycle.
module tb_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ImemReqValid, ImemReqReady = 1'b0;
  logic [31:0] ImemAddr;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  logic        funct7b5D;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D)
  );

  // ---------------- reference model state ----------------
  logic [31:0] m_pcf;
  logic [31:0] m_tags[$];
  logic [63:0] exp_q[$];
  int          m_drop;
  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_valid;

  logic [31:0] mem_addr_q[$];
  longint      mem_due_q[$];
  longint      edge_no = 0;
  int          lat = 1;
  int          resp_pct = 100;
  bit          spurious_en = 1'b0;

  logic        rst_v = 1'b0, stall_v = 1'b0, flush_v = 1'b0, pcsrc_v = 1'b0, ready_v = 1'b0;
  logic [31:0] target_v = '0;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h0000_0093 + (addr << 6);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcf = RESET_PC;
    m_tags.delete();
    exp_q.delete();
    m_drop  = 0;
    m_instr = NOP;
    m_pc    = '0;
    m_pc4   = '0;
    m_valid = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic step();
    logic        rv;
    logic [31:0] rd, tag;
    logic [63:0] head;
    logic        exp_req, acc;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (mem_addr_q.size() > 0) begin
      if (mem_due_q[0] <= edge_no + 1 && $urandom_range(99, 0) < resp_pct) begin
        rv = 1'b1;
        rd = mem_word(mem_addr_q[0]);
      end
    end else if (spurious_en && $urandom_range(3, 0) == 0) begin
      rv = 1'b1;
    end
    reset = rst_v; StallD = stall_v; FlushD = flush_v; PCSrcE = pcsrc_v;
    PCTargetE = target_v; ImemReqReady = ready_v;
    ImemRespValid = rv; ImemRespData = rd;
    if (!rst_v) model_reset();
    #1;
    exp_req = rst_v && (m_tags.size() + exp_q.size() < DEPTH) && !pcsrc_v;
    chk("req_valid", ImemReqValid, exp_req);
    chk("imem_addr", ImemAddr, m_pcf);
    acc = exp_req && ready_v;
    @(posedge clk);
    edge_no++;
    if (rst_v) begin
      if (pcsrc_v || flush_v) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!stall_v) begin
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          m_instr = head[63:32]; m_pc = head[31:0]; m_pc4 = head[31:0] + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
      if (rv && m_tags.size() > 0) begin
        tag = m_tags.pop_front();
        if (m_drop > 0) m_drop--;
        else if (!pcsrc_v) exp_q.push_back({rd, tag});
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
      if (pcsrc_v) begin
        exp_q.delete();
        m_drop = m_tags.size();
        m_pcf  = target_v;
      end else if (acc) begin
        m_tags.push_back(m_pcf);
        mem_addr_q.push_back(m_pcf);
        mem_due_q.push_back(edge_no + lat);
        m_pcf = m_pcf + 32'd4;
      end
    end
    #1;
    chk("instr_d", InstrD, m_instr);
    chk("pc_d", PCD, m_pc);
    chk("pc_plus4_d", PCPlus4D, m_pc4);
    chk("valid_d", ValidD, m_valid);
    chk("op_d", opD, m_instr[6:0]);
    chk("funct3_d", funct3D, m_instr[14:12]);
    chk("funct7b5_d", funct7b5D, m_instr[30]);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step();
      n++;
      if (ValidD) break;
    end
    chk("wait_valid_timeout", (n < budget || ValidD) ? 1 : 0, 1);
  endtask

  // ---------------- scenarios and report ----------------
  initial begin
    int          n;
    logic [31:0] prev_pc, frozen_pc, hold_addr;
    model_reset();

    // reset and straight-line fetch
    rst_v = 1'b0; ready_v = 1'b1; lat = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_instr", InstrD, NOP);
      chk("rst_valid", ValidD, 0);
      chk("rst_pc", PCD, 0);
      chk("rst_req", ImemReqValid, 0);
    end
    rst_v = 1'b1;
    steps(3);
    chk("first_valid", ValidD, 1);
    chk("first_pc", PCD, 32'h0);
    chk("first_instr", InstrD, 32'h0000_0093);
    chk("first_op", opD, 7'h13);
    step();
    chk("second_pc", PCD, 32'h4);
    chk("second_instr", InstrD, 32'h0000_0193);
    prev_pc = PCD;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("pcd_step", PCD, prev_pc + 32'd4);
      prev_pc = PCD;
    end

    // stall then flush
    frozen_pc = PCD;
    stall_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc_frozen", PCD, frozen_pc);
    end
    chk("buf_full", exp_q.size(), DEPTH);
    stall_v = 1'b0; flush_v = 1'b1;
    step();
    chk("flush_instr", InstrD, NOP);
    chk("flush_valid", ValidD, 0);
    flush_v = 1'b0;
    step();
    chk("after_flush_pc", PCD, frozen_pc + 32'd4);
    chk("after_flush_valid", ValidD, 1);
    steps(6);

    // request backpressure
    ready_v = 1'b0;
    hold_addr = ImemAddr;
    steps(5);
    chk("bp_addr_hold", ImemAddr, hold_addr);
    chk("bp_drained", ValidD, 0);
    ready_v = 1'b1;
    wait_valid(10, n);
    chk("bp_resume_pc", PCD, hold_addr);
    steps(4);

    // redirect with two requests in flight, latency 3
    lat = 3; ready_v = 1'b0;
    steps(6);
    ready_v = 1'b1;
    steps(2);
    chk("model_inflight_2", m_tags.size(), 2);
    ready_v = 1'b0; pcsrc_v = 1'b1; target_v = 32'h0000_0200;
    step();
    chk("redir_bubble", ValidD, 0);
    chk("model_drop_2", m_drop, 2);
    pcsrc_v = 1'b0; ready_v = 1'b1;
    wait_valid(20, n);
    chk("redir_latency", n, 5);
    chk("redir_pc0", PCD, 32'h0000_0200);
    chk("redir_instr0", InstrD, 32'h0000_8093);
    step();
    chk("redir_pc1", PCD, 32'h0000_0204);
    chk("redir_valid1", ValidD, 1);

    // redirect during stall
    lat = 1;
    steps(6);
    stall_v = 1'b1; pcsrc_v = 1'b1; target_v = 32'h0000_0400;
    step();
    chk("rs_valid", ValidD, 0);
    chk("rs_buf_clear", exp_q.size(), 0);
    stall_v = 1'b0; pcsrc_v = 1'b0;
    wait_valid(20, n);
    chk("rs_latency", n, 3);
    chk("rs_pc", PCD, 32'h0000_0400);

    // PC wrap past 2^32
    pcsrc_v = 1'b1; target_v = 32'hFFFF_FFF8;
    step();
    pcsrc_v = 1'b0;
    steps(8);

    // randomized traffic
    resp_pct = 75; spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      lat      = $urandom_range(4, 1);
      stall_v  = ($urandom_range(99, 0) < 20);
      flush_v  = ($urandom_range(99, 0) < 5);
      pcsrc_v  = ($urandom_range(99, 0) < 4);
      target_v = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
      ready_v  = ($urandom_range(99, 0) < 70);
      step();
    end
    stall_v = 1'b0; flush_v = 1'b0; pcsrc_v = 1'b0;
    resp_pct = 100; spurious_en = 1'b0;

    // asynchronous reset with two requests in flight
    lat = 3; ready_v = 1'b0;
    steps(8);
    chk("model_drained", m_tags.size(), 0);
    ready_v = 1'b1;
    steps(2);
    chk("model_inflight_2b", m_tags.size(), 2);
    ready_v = 1'b0;
    #2;
    rst_v = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_instr", InstrD, NOP);
    chk("async_valid", ValidD, 0);
    chk("async_pc", PCD, 0);
    chk("async_pc4", PCPlus4D, 0);
    chk("async_req", ImemReqValid, 0);
    chk("async_addr", ImemAddr, RESET_PC);
    model_reset();
    steps(2);
    rst_v = 1'b1; ready_v = 1'b1; lat = 1;
    steps(3);
    chk("restart_valid", ValidD, 1);
    chk("restart_pc", PCD, RESET_PC);
    steps(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
